// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the two-master MMIO bus arbiter.
//   state_t   : IDLE / ISSUE / ACK transaction sequencer states
//   M0, M1    : master index encoding used by grant_id and the RR pointer
package mmio_arb_pkg;

  localparam int unsigned N_MASTERS = 2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Master index of a one-hot two-bit grant vector.
  function automatic logic gnt_to_id(input logic [N_MASTERS-1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter, purely combinational.
//   req[1:0] : request per master
//   last     : master that won the previous grant
//   rr_en    : 1 = round-robin on ties, 0 = master 0 wins ties
//   gnt[1:0] : one-hot grant, zero when nobody requests
module rr_arb2
  import mmio_arb_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  logic                 last,
  input  logic                 rr_en,
  output logic [N_MASTERS-1:0] gnt
);

  // On a tie the round-robin mode hands the bus to whoever lost last time.
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && (last == M0)) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Arbitrates two MMIO requesters onto a single FPro-style bus.
// Each transaction takes IDLE (latch winner) -> ISSUE (one-cycle strobe)
// -> ACK (one-cycle ack pulse to the winner).
//   clk, reset            : clock, async active-low reset
//   m*_req/wr/addr/wr_data: requester commands, req held until ack
//   m*_ack, m*_rd_data    : completion pulse and held read result
//   mmio_cs/wr/rd/addr/wr_data, mmio_rd_data : downstream bus
//   grant_id              : owner of the current or last transaction
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RR_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data,
  output logic              grant_id
);

  state_t                state, state_d;
  logic [N_MASTERS-1:0]  gnt;
  logic                  win_id;
  logic                  win_wr;
  logic                  last_gnt;
  logic                  lat_wr;

  logic                  take;
  logic                  cap_rd;
  logic                  cs_d, wr_d, rd_d;
  logic                  ack0_d, ack1_d;

  rr_arb2 u_arb (
    .req   ({m1_req, m0_req}),
    .last  (last_gnt),
    .rr_en (RR_EN != 0),
    .gnt   (gnt)
  );

  assign win_id = gnt_to_id(gnt);
  assign win_wr = win_id ? m1_wr : m0_wr;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next state plus next values of the registered strobes and acks.
  always_comb begin
    state_d = state;
    take    = 1'b0;
    cap_rd  = 1'b0;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt != '0) begin
          state_d = ISSUE;
          take    = 1'b1;
          cs_d    = 1'b1;
          wr_d    = win_wr;
          rd_d    = !win_wr;
        end
      end
      ISSUE: begin
        state_d = ACK;
        cap_rd  = !lat_wr;
        ack0_d  = (grant_id == M0);
        ack1_d  = (grant_id == M1);
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus strobes and acks, one cycle behind the decision that produced them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_cs <= 1'b0;
      mmio_wr <= 1'b0;
      mmio_rd <= 1'b0;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
    end else begin
      mmio_cs <= cs_d;
      mmio_wr <= wr_d;
      mmio_rd <= rd_d;
      m0_ack  <= ack0_d;
      m1_ack  <= ack1_d;
    end
  end

  // Winner's command is captured once; the bus is driven only from here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_wr       <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      grant_id     <= M0;
      last_gnt     <= M1;  // pretend m1 won last so m0 is preferred
    end else if (take) begin
      lat_wr       <= win_wr;
      mmio_addr    <= win_id ? m1_addr : m0_addr;
      mmio_wr_data <= win_id ? m1_wr_data : m0_wr_data;
      grant_id     <= win_id;
      last_gnt     <= win_id;
    end
  end

  // Read data lands at the end of ISSUE into the owner's holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rd_data <= '0;
      m1_rd_data <= '0;
    end else if (cap_rd) begin
      if (grant_id == M1) m1_rd_data <= mmio_rd_data;
      else                m0_rd_data <= mmio_rd_data;
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// the same stimulus; each table row is one clock cycle of inputs and the
// outputs expected during that cycle.
module tb_mmio_bus_arbiter;

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;
  localparam int          NV = 29;

  localparam logic          T  = 1'b1;
  localparam logic          F  = 1'b0;
  localparam logic [AW-1:0] AZ = 21'h0;
  localparam logic [DW-1:0] DZ = 32'h0;
  localparam logic [AW-1:0] RA0 = 21'h00010;
  localparam logic [DW-1:0] RD0 = 32'hA0A0A0A0;
  localparam logic [AW-1:0] RA1 = 21'h00020;
  localparam logic [DW-1:0] RD1 = 32'hB1B1B1B1;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data, mmio_rd_data;

  logic          m0_ack, m1_ack, mmio_cs, mmio_wr, mmio_rd, grant_id;
  logic [DW-1:0] m0_rd_data, m1_rd_data, mmio_wr_data;
  logic [AW-1:0] mmio_addr;

  logic          f_ack0, f_ack1, f_cs, f_wr, f_rd, f_gid;
  logic [DW-1:0] f_q0, f_q1, f_wd;
  logic [AW-1:0] f_addr;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
    .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data), .grant_id(grant_id)
  );

  mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m0_ack(f_ack0), .m1_ack(f_ack1), .m0_rd_data(f_q0), .m1_rd_data(f_q1),
    .mmio_cs(f_cs), .mmio_wr(f_wr), .mmio_rd(f_rd), .mmio_addr(f_addr),
    .mmio_wr_data(f_wd), .mmio_rd_data(mmio_rd_data), .grant_id(f_gid)
  );

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [DW-1:0] bus;
    logic          cs, wr, rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          k0, k1, gid;
    logic [DW-1:0] q0, q1;
    logic          fk0, fk1, fgid;
  } vec_t;

  vec_t vt [NV];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " cs"},     32'(mmio_cs),      32'h0);
    chk({tag, " wr"},     32'(mmio_wr),      32'h0);
    chk({tag, " rd"},     32'(mmio_rd),      32'h0);
    chk({tag, " addr"},   32'(mmio_addr),    32'h0);
    chk({tag, " wdata"},  mmio_wr_data,      32'h0);
    chk({tag, " ack0"},   32'(m0_ack),       32'h0);
    chk({tag, " ack1"},   32'(m1_ack),       32'h0);
    chk({tag, " gid"},    32'(grant_id),     32'h0);
    chk({tag, " q0"},     m0_rd_data,        32'h0);
    chk({tag, " q1"},     m1_rd_data,        32'h0);
    chk({tag, " fp cs"},  32'(f_cs),         32'h0);
    chk({tag, " fp ack0"}, 32'(f_ack0),      32'h0);
    chk({tag, " fp ack1"}, 32'(f_ack1),      32'h0);
    chk({tag, " fp gid"}, 32'(f_gid),        32'h0);
    chk({tag, " fp addr"}, 32'(f_addr),      32'h0);
    chk({tag, " fp q0"},  f_q0,              32'h0);
  endtask

  task automatic apply_vec(input int i);
    vec_t  v;
    string p;
    v = vt[i];
    p = $sformatf("v%0d", i);
    m0_req = v.r0; m0_wr = v.w0; m0_addr = v.a0; m0_wr_data = v.d0;
    m1_req = v.r1; m1_wr = v.w1; m1_addr = v.a1; m1_wr_data = v.d1;
    mmio_rd_data = v.bus;
    #1;
    n_vec++;
    chk({p, " cs"},      32'(mmio_cs),   32'(v.cs));
    chk({p, " wr"},      32'(mmio_wr),   32'(v.wr));
    chk({p, " rd"},      32'(mmio_rd),   32'(v.rd));
    chk({p, " addr"},    32'(mmio_addr), 32'(v.addr));
    chk({p, " wdata"},   mmio_wr_data,   v.wd);
    chk({p, " ack0"},    32'(m0_ack),    32'(v.k0));
    chk({p, " ack1"},    32'(m1_ack),    32'(v.k1));
    chk({p, " gid"},     32'(grant_id),  32'(v.gid));
    chk({p, " q0"},      m0_rd_data,     v.q0);
    chk({p, " q1"},      m1_rd_data,     v.q1);
    chk({p, " fp ack0"}, 32'(f_ack0),    32'(v.fk0));
    chk({p, " fp ack1"}, 32'(f_ack1),    32'(v.fk1));
    chk({p, " fp gid"},  32'(f_gid),     32'(v.fgid));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Both masters hold req for four transactions.
    vt[0]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  F,F,F,AZ,DZ,   F,F,F, DZ,DZ, F,F,F};
    vt[1]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  T,T,F,RA0,RD0, F,F,F, DZ,DZ, F,F,F};
    vt[2]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  F,F,F,RA0,RD0, T,F,F, DZ,DZ, T,F,F};
    vt[3]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  F,F,F,RA0,RD0, F,F,F, DZ,DZ, F,F,F};
    vt[4]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  T,T,F,RA1,RD1, F,F,T, DZ,DZ, F,F,F};
    vt[5]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  F,F,F,RA1,RD1, F,T,T, DZ,DZ, T,F,F};
    vt[6]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  F,F,F,RA1,RD1, F,F,T, DZ,DZ, F,F,F};
    vt[7]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  T,T,F,RA0,RD0, F,F,F, DZ,DZ, F,F,F};
    vt[8]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  F,F,F,RA0,RD0, T,F,F, DZ,DZ, T,F,F};
    vt[9]  = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  F,F,F,RA0,RD0, F,F,F, DZ,DZ, F,F,F};
    vt[10] = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  T,T,F,RA1,RD1, F,F,T, DZ,DZ, F,F,F};
    vt[11] = '{T,T,RA0,RD0, T,T,RA1,RD1, DZ,  F,F,F,RA1,RD1, F,T,T, DZ,DZ, T,F,F};
    vt[12] = '{F,F,AZ,DZ,   F,F,AZ,DZ,   DZ,  F,F,F,RA1,RD1, F,F,T, DZ,DZ, F,F,F};
    // m0 write 0xC4 <- 0xDEADBEEF, m1 idle.
    vt[13] = '{T,T,21'h000C4,32'hDEADBEEF, F,F,AZ,DZ, DZ, F,F,F,RA1,RD1, F,F,T, DZ,DZ, F,F,F};
    vt[14] = '{T,T,21'h000C4,32'hDEADBEEF, F,F,AZ,DZ, DZ, T,T,F,21'h000C4,32'hDEADBEEF, F,F,F, DZ,DZ, F,F,F};
    vt[15] = '{T,T,21'h000C4,32'hDEADBEEF, F,F,AZ,DZ, DZ, F,F,F,21'h000C4,32'hDEADBEEF, T,F,F, DZ,DZ, T,F,F};
    vt[16] = '{F,F,AZ,DZ, F,F,AZ,DZ, DZ, F,F,F,21'h000C4,32'hDEADBEEF, F,F,F, DZ,DZ, F,F,F};
    // m1 read 0x60, bus returns 0xA5A5 only in the strobe cycle.
    vt[17] = '{F,F,AZ,DZ, T,F,21'h00060,DZ, DZ, F,F,F,21'h000C4,32'hDEADBEEF, F,F,F, DZ,DZ, F,F,F};
    vt[18] = '{F,F,AZ,DZ, T,F,21'h00060,DZ, 32'h0000A5A5, T,F,T,21'h00060,DZ, F,F,T, DZ,DZ, F,F,T};
    vt[19] = '{F,F,AZ,DZ, T,F,21'h00060,DZ, DZ, F,F,F,21'h00060,DZ, F,T,T, DZ,32'h0000A5A5, F,T,T};
    vt[20] = '{F,F,AZ,DZ, F,F,AZ,DZ, DZ, F,F,F,21'h00060,DZ, F,F,T, DZ,32'h0000A5A5, F,F,T};
    // m0 read while idle m1 wiggles addr/data; m0 drops req in its ack cycle.
    vt[21] = '{T,F,21'h00100,32'h11111111, F,F,21'h1FFFF,32'hCAFEF00D, DZ, F,F,F,21'h00060,DZ, F,F,T, DZ,32'h0000A5A5, F,F,T};
    vt[22] = '{T,F,21'h00100,32'h11111111, F,F,21'h0AAAA,32'h12345678, 32'h0BADC0DE, T,F,T,21'h00100,32'h11111111, F,F,F, DZ,32'h0000A5A5, F,F,F};
    vt[23] = '{F,F,21'h00100,32'h11111111, F,F,21'h15555,32'h87654321, 32'hFFFFFFFF, F,F,F,21'h00100,32'h11111111, T,F,F, 32'h0BADC0DE,32'h0000A5A5, T,F,F};
    vt[24] = '{F,F,AZ,DZ, F,F,AZ,DZ, DZ, F,F,F,21'h00100,32'h11111111, F,F,F, 32'h0BADC0DE,32'h0000A5A5, F,F,F};
    // m1 write dropping req in ISSUE; rd_data must not change.
    vt[25] = '{F,F,AZ,DZ, T,T,21'h00033,32'h5A5A5A5A, DZ, F,F,F,21'h00100,32'h11111111, F,F,F, 32'h0BADC0DE,32'h0000A5A5, F,F,F};
    vt[26] = '{F,F,AZ,DZ, F,T,21'h00033,32'h5A5A5A5A, DZ, T,T,F,21'h00033,32'h5A5A5A5A, F,F,T, 32'h0BADC0DE,32'h0000A5A5, F,F,T};
    vt[27] = '{F,F,AZ,DZ, F,T,21'h00033,32'h5A5A5A5A, DZ, F,F,F,21'h00033,32'h5A5A5A5A, F,T,T, 32'h0BADC0DE,32'h0000A5A5, F,T,T};
    vt[28] = '{F,F,AZ,DZ, F,F,AZ,DZ, DZ, F,F,F,21'h00033,32'h5A5A5A5A, F,F,T, 32'h0BADC0DE,32'h0000A5A5, F,F,T};

    reset = 1'b0;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wr_data = '0;
    mmio_rd_data = '0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply_vec(i);
    end

    // m0 read aborted by reset in its ISSUE cycle.
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00044; m0_wr_data = DZ;
    #1;
    n_vec++;
    chk("abort pre cs", 32'(mmio_cs), 32'h0);
    @(posedge clk);
    #1;
    n_vec++;
    chk("abort issue cs",   32'(mmio_cs),   32'h1);
    chk("abort issue rd",   32'(mmio_rd),   32'h1);
    chk("abort issue addr", 32'(mmio_addr), 32'h00044);
    chk("abort issue gid",  32'(grant_id),  32'h0);
    @(negedge clk);
    reset  = 1'b0;
    m0_req = 1'b0;
    #1;
    n_vec++;
    chk_zero("abort async");
    @(posedge clk);
    #1;
    n_vec++;
    chk_zero("abort held");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_vec++;
      chk_zero($sformatf("post-release c%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
